// File: rtl/mips_hazard_pkg.sv
// Shared encodings for the MIPS hazard scoreboard: forwarding selects and
// syscall register numbers.
package mips_hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  localparam int V0_REG_C = 2;
  localparam int A0_REG_C = 4;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Pipeline-register view and stage-control outputs of the hazard scoreboard.
interface hazard_scoreboard_if #(
  parameter int REG_W  = 5,
  parameter int PERF_W = 32
);

  logic [REG_W-1:0]  RsD, RtD;
  logic              BranchD, syscallD, MfOpInD, DivD, is_trap, pc_src_d;
  logic [REG_W-1:0]  RsE, RtE, WriteRegE;
  logic              MemtoRegE, RegWriteE, HasDivE, DivStartE;
  logic [REG_W-1:0]  WriteRegM;
  logic              RegWriteM, HasDivM;
  logic [REG_W-1:0]  WriteRegW;
  logic              RegWriteW, HasDivW;

  logic              StallF, StallD, FlushE, FlushD;
  logic [1:0]        ForwardAE, ForwardBE;
  logic              div_busy, stall_timeout;
  logic [PERF_W-1:0] stall_cycles;

  modport master (
    output RsD, RtD, BranchD, syscallD, MfOpInD, DivD, is_trap, pc_src_d,
           RsE, RtE, WriteRegE, MemtoRegE, RegWriteE, HasDivE, DivStartE,
           WriteRegM, RegWriteM, HasDivM, WriteRegW, RegWriteW, HasDivW,
    input  StallF, StallD, FlushE, FlushD, ForwardAE, ForwardBE,
           div_busy, stall_timeout, stall_cycles
  );

  modport slave (
    input  RsD, RtD, BranchD, syscallD, MfOpInD, DivD, is_trap, pc_src_d,
           RsE, RtE, WriteRegE, MemtoRegE, RegWriteE, HasDivE, DivStartE,
           WriteRegM, RegWriteM, HasDivM, WriteRegW, RegWriteW, HasDivW,
    output StallF, StallD, FlushE, FlushD, ForwardAE, ForwardBE,
           div_busy, stall_timeout, stall_cycles
  );

endinterface

// File: rtl/hazard_div_tracker.sv
// Busy countdown for the multi-cycle divider; a start (re)loads the full latency.
module hazard_div_tracker #(
  parameter int DIV_LATENCY = 32
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  output logic busy
);

  localparam int CNT_W = $clog2(DIV_LATENCY + 1);

  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (start) begin
      div_cnt_d = CNT_W'(DIV_LATENCY);
    end else if (div_cnt_q != '0) begin
      div_cnt_d = div_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  assign busy = (div_cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard unit for the 5-stage MIPS core: forwarding, interlocks, divider
// tracking, stall watchdog and stall-cycle counter.
module hazard_scoreboard
  import mips_hazard_pkg::*;
#(
  parameter int REG_W         = 5,
  parameter int DIV_LATENCY   = 32,
  parameter int STALL_TIMEOUT = 1024,
  parameter int PERF_W        = 32,
  parameter int V0_REG        = V0_REG_C,
  parameter int A0_REG        = A0_REG_C
) (
  input logic             clock,
  input logic             reset,
  hazard_scoreboard_if.slave hz
);

  localparam int RUN_W = $clog2(STALL_TIMEOUT + 1);

  logic                lw_stall, branch_stall, syscall_stall, mf_stall, div_stall;
  logic                stall;
  logic                div_busy;
  logic [RUN_W-1:0]    stall_run_q, stall_run_d;
  logic                stall_timeout_q, stall_timeout_d;
  logic [PERF_W-1:0]   stall_cycles_q, stall_cycles_d;

  function automatic fwd_sel_e fwd_sel(
    input logic [REG_W-1:0] src,
    input logic [REG_W-1:0] dst_m,
    input logic             wr_m,
    input logic [REG_W-1:0] dst_w,
    input logic             wr_w
  );
    if (src != '0 && src == dst_m && wr_m) begin
      return FWD_M;
    end else if (src != '0 && src == dst_w && wr_w) begin
      return FWD_W;
    end
    return FWD_RF;
  endfunction

  function automatic logic is_sys_reg(input logic [REG_W-1:0] r);
    return (r == REG_W'(V0_REG)) || (r == REG_W'(A0_REG));
  endfunction

  hazard_div_tracker #(
    .DIV_LATENCY(DIV_LATENCY)
  ) u_div_tracker (
    .clock(clock),
    .reset(reset),
    .start(hz.DivStartE),
    .busy (div_busy)
  );

  always_comb begin
    lw_stall = hz.MemtoRegE && (hz.RtE != '0) &&
               ((hz.RsD == hz.RtE) || (hz.RtD == hz.RtE));

    branch_stall = hz.BranchD && (
      (hz.RegWriteE && (hz.WriteRegE != '0) &&
       ((hz.WriteRegE == hz.RsD) || (hz.WriteRegE == hz.RtD))) ||
      (hz.RegWriteM && (hz.WriteRegM != '0) &&
       ((hz.WriteRegM == hz.RsD) || (hz.WriteRegM == hz.RtD))));

    syscall_stall = hz.syscallD && (
      (hz.RegWriteE && is_sys_reg(hz.WriteRegE)) ||
      (hz.RegWriteM && is_sys_reg(hz.WriteRegM)) ||
      (hz.RegWriteW && is_sys_reg(hz.WriteRegW)));

    mf_stall  = hz.MfOpInD && (hz.HasDivE || hz.HasDivM || hz.HasDivW || div_busy);
    div_stall = hz.DivD && div_busy;

    stall = lw_stall || branch_stall || syscall_stall || mf_stall || div_stall;
  end

  assign hz.StallF    = !stall;
  assign hz.StallD    = !stall;
  assign hz.FlushE    = !stall;
  // A taken branch must not discard the decode slot it is currently holding.
  assign hz.FlushD    = !(hz.is_trap || (hz.pc_src_d && !stall));
  assign hz.ForwardAE = fwd_sel(hz.RsE, hz.WriteRegM, hz.RegWriteM, hz.WriteRegW, hz.RegWriteW);
  assign hz.ForwardBE = fwd_sel(hz.RtE, hz.WriteRegM, hz.RegWriteM, hz.WriteRegW, hz.RegWriteW);
  assign hz.div_busy      = div_busy;
  assign hz.stall_timeout = stall_timeout_q;
  assign hz.stall_cycles  = stall_cycles_q;

  always_comb begin
    stall_run_d     = '0;
    stall_timeout_d = stall_timeout_q;
    stall_cycles_d  = stall_cycles_q;
    if (stall) begin
      stall_run_d = (stall_run_q == RUN_W'(STALL_TIMEOUT)) ? stall_run_q
                                                           : stall_run_q + RUN_W'(1);
      if (stall_cycles_q != '1) begin
        stall_cycles_d = stall_cycles_q + PERF_W'(1);
      end
    end
    // Timeout latches on the edge the run length reaches the limit.
    if (stall_run_d == RUN_W'(STALL_TIMEOUT)) begin
      stall_timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_run_q     <= '0;
      stall_timeout_q <= 1'b0;
      stall_cycles_q  <= '0;
    end else begin
      stall_run_q     <= stall_run_d;
      stall_timeout_q <= stall_timeout_d;
      stall_cycles_q  <= stall_cycles_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with DIV_LATENCY=4, STALL_TIMEOUT=8, PERF_W=4.
module tb_hazard_scoreboard;

  localparam int REG_W = 5;
  localparam int PERF_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  hazard_scoreboard_if #(.REG_W(REG_W), .PERF_W(PERF_W)) hif ();

  hazard_scoreboard #(
    .REG_W(REG_W), .DIV_LATENCY(4), .STALL_TIMEOUT(8), .PERF_W(PERF_W),
    .V0_REG(2), .A0_REG(4)
  ) dut (
    .clock(clk),
    .reset(rst_n),
    .hz   (hif.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: sim time limit reached, got running expected finished");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    hif.RsD = '0; hif.RtD = '0; hif.BranchD = 0; hif.syscallD = 0; hif.MfOpInD = 0;
    hif.DivD = 0; hif.is_trap = 0; hif.pc_src_d = 0;
    hif.RsE = '0; hif.RtE = '0; hif.WriteRegE = '0;
    hif.MemtoRegE = 0; hif.RegWriteE = 0; hif.HasDivE = 0; hif.DivStartE = 0;
    hif.WriteRegM = '0; hif.RegWriteM = 0; hif.HasDivM = 0;
    hif.WriteRegW = '0; hif.RegWriteW = 0; hif.HasDivW = 0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    clear_inputs();
    #3;
    check("rst_stallf", hif.StallF, 1);
    check("rst_flushe", hif.FlushE, 1);
    check("rst_flushd", hif.FlushD, 1);
    check("rst_fwda", hif.ForwardAE, 0);
    check("rst_busy", hif.div_busy, 0);
    check("rst_cycles", hif.stall_cycles, 0);
    check("rst_tmo", hif.stall_timeout, 0);
    @(negedge clk) rst_n = 1'b1;

    // Load-use: one stalled cycle
    tick();
    hif.MemtoRegE = 1; hif.RtE = 8; hif.RsD = 8;
    #1;
    check("lw_stallf", hif.StallF, 0);
    check("lw_stalld", hif.StallD, 0);
    check("lw_flushe", hif.FlushE, 0);
    tick();
    clear_inputs();
    #1;
    check("lw_cycles", hif.stall_cycles, 1);
    check("lw_release", hif.StallF, 1);

    // Forwarding priority
    hif.RsE = 9; hif.WriteRegM = 9; hif.RegWriteM = 1; hif.WriteRegW = 9; hif.RegWriteW = 1;
    #1; check("fwd_m_prio", hif.ForwardAE, 2'b10);
    hif.RegWriteM = 0;
    #1; check("fwd_w", hif.ForwardAE, 2'b01);
    hif.RegWriteM = 1; hif.RsE = 0;
    #1; check("fwd_r0", hif.ForwardAE, 2'b00);
    hif.RtE = 5; hif.WriteRegM = 6; hif.WriteRegW = 5;
    #1; check("fwd_b_w", hif.ForwardBE, 2'b01);
    clear_inputs();

    // Branch compare interlock and decode flush
    hif.BranchD = 1; hif.RsD = 3; hif.RegWriteE = 1; hif.WriteRegE = 3;
    #1; check("br_stall", hif.StallD, 0);
    hif.pc_src_d = 1;
    #1; check("br_hold_flushd", hif.FlushD, 1);
    hif.WriteRegE = 0; hif.RsD = 0;
    #1; check("br_r0", hif.StallD, 1);
    check("br_taken_flushd", hif.FlushD, 0);
    hif.RtD = 7; hif.RegWriteM = 1; hif.WriteRegM = 7;
    #1; check("br_m_stall", hif.StallD, 0);
    clear_inputs();
    hif.is_trap = 1;
    #1; check("trap_flushd", hif.FlushD, 0);
    clear_inputs();

    // Syscall interlock
    hif.syscallD = 1; hif.WriteRegM = 2; hif.RegWriteM = 1;
    #1; check("sys_v0", hif.StallF, 0);
    hif.RegWriteM = 0;
    #1; check("sys_nowr", hif.StallF, 1);
    hif.WriteRegW = 4; hif.RegWriteW = 1;
    #1; check("sys_a0_w", hif.StallF, 0);
    clear_inputs();

    // Divider countdown with mf interlock
    pulse_reset();
    tick();
    hif.DivStartE = 1;
    #1; check("div_c0_busy", hif.div_busy, 0);
    tick();
    hif.DivStartE = 0; hif.MfOpInD = 1;
    for (int c = 1; c <= 4; c++) begin
      #1;
      check($sformatf("div_c%0d_busy", c), hif.div_busy, 1);
      check($sformatf("div_c%0d_stalld", c), hif.StallD, 0);
      tick();
    end
    #1;
    check("div_c5_busy", hif.div_busy, 0);
    check("div_c5_stalld", hif.StallD, 1);
    check("div_cycles", hif.stall_cycles, 4);
    hif.HasDivE = 1;
    #1; check("mf_hasdive", hif.StallD, 0);
    clear_inputs();

    // Divider restart and div interlock
    hif.DivStartE = 1; tick(); hif.DivStartE = 0; tick();
    hif.DivStartE = 1; tick(); hif.DivStartE = 0;
    hif.DivD = 1;
    #1; check("div_divstall", hif.StallD, 0);
    hif.DivD = 0;
    tick(); tick(); tick();
    check("div_restart_busy", hif.div_busy, 1);
    tick();
    check("div_restart_done", hif.div_busy, 0);

    // Async reset mid-division
    pulse_reset();
    tick();
    hif.DivStartE = 1; tick();
    hif.DivStartE = 0; hif.MfOpInD = 1; tick();
    check("ar_pre_busy", hif.div_busy, 1);
    check("ar_pre_cycles", hif.stall_cycles, 1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_busy", hif.div_busy, 0);
    check("ar_cycles", hif.stall_cycles, 0);
    check("ar_stalld", hif.StallD, 1);
    rst_n = 1'b1;
    clear_inputs();

    // Watchdog
    tick();
    hif.MemtoRegE = 1; hif.RtE = 8; hif.RsD = 8;
    for (int k = 0; k < 7; k++) tick();
    check("wd_7", hif.stall_timeout, 0);
    tick();
    check("wd_8", hif.stall_timeout, 1);
    clear_inputs();
    tick(); tick(); tick();
    check("wd_sticky", hif.stall_timeout, 1);
    check("wd_cycles", hif.stall_cycles, 8);
    rst_n = 1'b0;
    #1;
    check("wd_reset", hif.stall_timeout, 0);
    rst_n = 1'b1;

    // Perf counter saturation at all-ones
    tick();
    hif.MemtoRegE = 1; hif.RtE = 8; hif.RtD = 8;
    for (int k = 0; k < 20; k++) tick();
    check("perf_sat", hif.stall_cycles, 15);
    clear_inputs();
    tick();
    check("perf_hold", hif.stall_cycles, 15);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the pipeline hazard unit for the 5-stage MIPS core. Sits between the decode/execute/memory/writeback pipeline registers and the stage enable/clear inputs.
- Adds sequential tracking of a multi-cycle divider (busy countdown) and a stall watchdog with a sticky timeout flag.
- Adds a saturating stall-cycle performance counter.
- Keeps combinational forwarding, load-use, branch-compare and syscall interlocks, generalised in register-address width.

Parameters:
- REG_W, 5, register address width.
- DIV_LATENCY, 32, cycles the divider stays busy after a start; must be >= 1.
- STALL_TIMEOUT, 1024, consecutive stall cycles before stall_timeout is set; must be >= 2.
- PERF_W, 32, width of the stall-cycle counter.
- V0_REG, 2, syscall number register.
- A0_REG, 4, syscall argument register.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- RsD, RtD  in  REG_W  decode source registers.
- BranchD  in  1  branch in decode.
- syscallD  in  1  syscall in decode.
- MfOpInD  in  1  mfhi/mflo in decode.
- DivD  in  1  div/divu in decode.
- is_trap  in  1  trap detected in decode.
- pc_src_d  in  1  branch/jump taken in decode.
- RsE, RtE, WriteRegE  in  REG_W  execute registers.
- MemtoRegE, RegWriteE, HasDivE  in  1  execute controls.
- DivStartE  in  1  divider start pulse, valid when execute advances.
- WriteRegM  in  REG_W  memory-stage destination register.
- RegWriteM, HasDivM  in  1  memory-stage controls.
- WriteRegW  in  REG_W  writeback destination register.
- RegWriteW, HasDivW  in  1  writeback controls.
- StallF, StallD  out  1  fetch/decode enables; 1 = advance, 0 = hold.
- FlushE  out  1  execute register clear, active-low; 0 = insert bubble.
- FlushD  out  1  decode register clear, active-low; 0 = clear.
- ForwardAE, ForwardBE  out  2  2'b10 = from M, 2'b01 = from W, 2'b00 = register file.
- div_busy  out  1  divider countdown nonzero.
- stall_timeout  out  1  sticky watchdog error.
- stall_cycles  out  PERF_W  saturating count of stalled cycles.

Behaviour:
- Reset (reset==0, asynchronous): div_cnt=0, stall_run=0, stall_timeout=0, stall_cycles=0. The combinational outputs then follow their inputs; with all inputs 0 the outputs are StallF=StallD=FlushE=1, ForwardAE=ForwardBE=0, div_busy=0.
- Forwarding, per operand X in {Rs, Rt}:
  - 2'b10 if XE!=0 && XE==WriteRegM && RegWriteM.
  - else 2'b01 if XE!=0 && XE==WriteRegW && RegWriteW.
  - else 2'b00. M has priority over W.
- lwStall = MemtoRegE && RtE!=0 && (RsD==RtE || RtD==RtE).
- branchStall = BranchD && any of:
  - RegWriteE && WriteRegE!=0 && WriteRegE matches RsD or RtD;
  - RegWriteM && WriteRegM!=0 && WriteRegM matches RsD or RtD.
- syscallStall = syscallD && (WriteRegE, WriteRegM or WriteRegW equals V0_REG or A0_REG, with the matching RegWrite set).
- Divider interlock:
  - mfStall = MfOpInD && (HasDivE || HasDivM || HasDivW || div_cnt!=0).
  - divStall = DivD && div_cnt!=0.
- stall = OR of lwStall, branchStall, syscallStall, mfStall, divStall.
- StallF = StallD = FlushE = !stall.
- FlushD = !(is_trap || (pc_src_d && !stall)): a taken branch does not clear decode while decode is held.
- div_cnt, width $clog2(DIV_LATENCY+1), updated on each rising edge:
  - DivStartE loads DIV_LATENCY (also when nonzero: restart).
  - else if nonzero, decrements by 1.
  - div_busy = (div_cnt!=0).
  - A start in cycle t gives busy for cycles t+1 .. t+DIV_LATENCY.
- Watchdog, stall_run of width $clog2(STALL_TIMEOUT+1):
  - stall=1 increments stall_run, saturating at STALL_TIMEOUT; stall=0 clears it.
  - stall_timeout sets on the edge where stall_run reaches STALL_TIMEOUT and holds until reset.
- Perf counter: stall_cycles increments every cycle stall=1 and saturates at all-ones. It never wraps.
- Reset asserted mid-division or mid-stall clears all counters immediately. The outputs re-evaluate from the inputs alone.

Decomposition:
- Shared package mips_hazard_pkg holds:
  - forwarding-select encodings FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10;
  - V0/A0 register constants.
- One sub-module: hazard_div_tracker, holding the div_cnt countdown and div_busy; it has parameter DIV_LATENCY.
- Watchdog and perf counter stay inline.

Test Plan:
- Load-use: MemtoRegE=1, RtE=8, RsD=8 -> StallF=StallD=FlushE=0 for 1 cycle; stall_cycles 0->1.
- Forward priority: RsE=9, WriteRegM=9/RegWriteM=1, WriteRegW=9/RegWriteW=1 -> ForwardAE=2'b10. RsE=0 with the same matches -> 2'b00.
- Divider: DIV_LATENCY=4, DivStartE pulse at cycle 0, MfOpInD=1 from cycle 1 -> div_busy=1 and StallD=0 for cycles 1-4; StallD=1 at cycle 5.
- Syscall: syscallD=1, WriteRegM=2, RegWriteM=1 -> stall. The same with RegWriteM=0 -> no stall.
- Watchdog: STALL_TIMEOUT=8, hold lwStall 8 cycles -> stall_timeout=1 after the 8th edge; remains 1 after the stall clears until reset=0.
- Async reset mid-division: assert reset at cycle 2 of a divide -> div_busy=0 and stall_cycles=0 immediately, without waiting for a clock edge.
